// File: rtl/dp_regmx_pkg.sv
// Shared limits and helpers for the one-hot-selected register pipeline.
// Parity-related helpers are used only when DP_REGMX_PARITY_EN is defined.
package dp_regmx_pkg;

    localparam int WIDTH_MAX  = 64;
    localparam int NUM_IN_MAX = 8;
    localparam int DEPTH_MAX  = 4;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_kind_e;

    function automatic sel_kind_e onehot_chk(input logic [NUM_IN_MAX-1:0] sel);
        int ones;
        ones = 0;
        for (int i = 0; i < NUM_IN_MAX; i++) begin
            ones = ones + int'(sel[i]);
        end
        if (ones == 0) begin
            return SEL_NONE;
        end else if (ones == 1) begin
            return SEL_ONE;
        end
        return SEL_MULTI;
    endfunction

    // Bit that makes the total number of ones (data plus bit) even.
    function automatic logic even_parity(input logic [WIDTH_MAX-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dp_regmx_stage.sv
// One pipeline stage: data, valid and (with DP_REGMX_PARITY_EN) a parity bit.
// Data and valid have separate load enables so the head stage can bubble without losing data.
module dp_regmx_stage
    import dp_regmx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_data,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_valid,
`ifdef DP_REGMX_PARITY_EN
    input  logic             src_parity,
    output logic             parity,
`endif
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
`ifdef DP_REGMX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            if (load_data) begin
                data <= src_data;
`ifdef DP_REGMX_PARITY_EN
                parity <= src_parity;
`endif
            end
            if (load_valid) begin
                valid <= src_valid;
            end
        end
    end

endmodule

// File: rtl/dp_regmxn_pipe.sv
// NUM_IN-way one-hot mux feeding a DEPTH-stage register pipeline with stall and select-error flag.
// Optional carried even parity and parity_err output when DP_REGMX_PARITY_EN is defined.
module dp_regmxn_pipe
    import dp_regmx_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] input_data,
    input  logic [NUM_IN-1:0]       select,
    input  logic                    stall,
    output logic [WIDTH-1:0]        output_data,
    output logic                    output_valid,
    output logic                    select_err
`ifdef DP_REGMX_PARITY_EN
    ,
    output logic                    parity_err
`endif
);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("dp_regmxn_pipe: WIDTH %0d outside 1..%0d", WIDTH, WIDTH_MAX);
    end
    if (NUM_IN < 2 || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
        $error("dp_regmxn_pipe: NUM_IN %0d outside 2..%0d", NUM_IN, NUM_IN_MAX);
    end
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("dp_regmxn_pipe: DEPTH %0d outside 1..%0d", DEPTH, DEPTH_MAX);
    end

    logic [NUM_IN_MAX-1:0] select_ext;
    sel_kind_e             sel_kind;
    logic [WIDTH-1:0]      mux_data;
    logic                  advance;
    logic                  capture;
    logic                  head_valid;

    logic [WIDTH-1:0]      stage_data  [DEPTH];
    logic                  stage_valid [DEPTH];

    always_comb begin
        select_ext             = '0;
        select_ext[NUM_IN-1:0] = select;
    end

    assign sel_kind = onehot_chk(select_ext);

    // AND-OR mux; only meaningful when the select is one-hot, which is the only case that loads.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            mux_data = mux_data | (input_data[k*WIDTH +: WIDTH] & {WIDTH{select[k]}});
        end
    end

    assign advance    = ~stall;
    assign head_valid = (sel_kind == SEL_ONE);
    assign capture    = advance & head_valid;

`ifdef DP_REGMX_PARITY_EN
    logic [WIDTH_MAX-1:0] mux_ext;
    logic [WIDTH_MAX-1:0] out_ext;
    logic                 mux_parity;
    logic                 stage_parity [DEPTH];

    always_comb begin
        mux_ext            = '0;
        mux_ext[WIDTH-1:0] = mux_data;
        out_ext            = '0;
        out_ext[WIDTH-1:0] = output_data;
    end

    assign mux_parity = even_parity(mux_ext);
`endif

    for (genvar n = 0; n < DEPTH; n++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_valid;
        logic             load_data;
`ifdef DP_REGMX_PARITY_EN
        logic             src_parity;
`endif

        if (n == 0) begin : g_head
            assign src_data  = mux_data;
            assign src_valid = head_valid;
            assign load_data = capture;
`ifdef DP_REGMX_PARITY_EN
            assign src_parity = mux_parity;
`endif
        end else begin : g_tail
            assign src_data  = stage_data[n-1];
            assign src_valid = stage_valid[n-1];
            assign load_data = advance;
`ifdef DP_REGMX_PARITY_EN
            assign src_parity = stage_parity[n-1];
`endif
        end

        dp_regmx_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .load_data  (load_data),
            .load_valid (advance),
            .src_data   (src_data),
            .src_valid  (src_valid),
`ifdef DP_REGMX_PARITY_EN
            .src_parity (src_parity),
            .parity     (stage_parity[n]),
`endif
            .data       (stage_data[n]),
            .valid      (stage_valid[n])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            select_err <= 1'b0;
        end else if (advance) begin
            select_err <= (sel_kind == SEL_MULTI);
        end
    end

    assign output_data  = stage_data[DEPTH-1];
    assign output_valid = stage_valid[DEPTH-1];

`ifdef DP_REGMX_PARITY_EN
    assign parity_err = output_valid & (even_parity(out_ext) != stage_parity[DEPTH-1]);
`endif

endmodule

// File: tb/tb_dp_regmxn_pipe.sv
// Directed-vector bench for dp_regmxn_pipe (WIDTH=16, NUM_IN=2, DEPTH=2).
// With DP_REGMX_PARITY_EN defined it also exercises parity_err via a forced stage-1 bit flip.
module tb_dp_regmxn_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] input_data;
    logic [1:0]  select;
    logic        stall;
    logic [15:0] output_data;
    logic        output_valid;
    logic        select_err;
`ifdef DP_REGMX_PARITY_EN
    logic        parity_err;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dp_regmxn_pipe #(
        .WIDTH  (16),
        .NUM_IN (2),
        .DEPTH  (2)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .select       (select),
        .stall        (stall),
        .output_data  (output_data),
        .output_valid (output_valid),
        .select_err   (select_err)
`ifdef DP_REGMX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic        stl;
        logic [1:0]  sel;
        logic [15:0] in0;
        logic [15:0] in1;
        logic [15:0] exp_d;
        logic        exp_v;
        logic        exp_e;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    initial begin
        // Each row is driven, one rising edge passes, then outputs are compared.
        tbl = '{
            // reset held with stall and a valid select
            '{1'b1, 1'b1, 2'b01, 16'hA5A5, 16'h5A5A, 16'h0000, 1'b0, 1'b0},
            '{1'b1, 1'b1, 2'b01, 16'hA5A5, 16'h5A5A, 16'h0000, 1'b0, 1'b0},
            '{1'b1, 1'b1, 2'b01, 16'hA5A5, 16'h5A5A, 16'h0000, 1'b0, 1'b0},
            // basic capture from each input, then zero / multi-hot selects
            '{1'b0, 1'b0, 2'b01, 16'hA5A5, 16'h5A5A, 16'h0000, 1'b0, 1'b0},
            '{1'b0, 1'b0, 2'b10, 16'hA5A5, 16'h5A5A, 16'hA5A5, 1'b1, 1'b0},
            '{1'b0, 1'b0, 2'b00, 16'hA5A5, 16'h5A5A, 16'h5A5A, 1'b1, 1'b0},
            '{1'b0, 1'b0, 2'b11, 16'hA5A5, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1},
            '{1'b0, 1'b0, 2'b00, 16'hA5A5, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0},
            // three items with a two-cycle stall mid-stream
            '{1'b0, 1'b0, 2'b01, 16'h0001, 16'h0000, 16'h5A5A, 1'b0, 1'b0},
            '{1'b0, 1'b0, 2'b01, 16'h0002, 16'h0000, 16'h0001, 1'b1, 1'b0},
            '{1'b0, 1'b1, 2'b01, 16'h0003, 16'h0000, 16'h0001, 1'b1, 1'b0},
            '{1'b0, 1'b1, 2'b01, 16'h0003, 16'h0000, 16'h0001, 1'b1, 1'b0},
            '{1'b0, 1'b0, 2'b01, 16'h0003, 16'h0000, 16'h0002, 1'b1, 1'b0},
            '{1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0003, 1'b1, 1'b0},
            '{1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b0},
            // select_err holds through a stall, clears on the next clean cycle
            '{1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b1},
            '{1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b1},
            '{1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b0},
            // reset pulse with two items in flight
            '{1'b0, 1'b0, 2'b01, 16'h0011, 16'h0000, 16'h0003, 1'b0, 1'b0},
            '{1'b0, 1'b0, 2'b01, 16'h0022, 16'h0000, 16'h0011, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'b01, 16'h0033, 16'h0000, 16'h0000, 1'b0, 1'b0},
            '{1'b0, 1'b0, 2'b01, 16'h0044, 16'h0000, 16'h0000, 1'b0, 1'b0},
            '{1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0044, 1'b1, 1'b0},
            '{1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0044, 1'b0, 1'b0},
            // reset overriding stall, clearing a pending select_err
            '{1'b0, 1'b0, 2'b01, 16'h0055, 16'h0000, 16'h0044, 1'b0, 1'b0},
            '{1'b0, 1'b0, 2'b11, 16'h0066, 16'h0000, 16'h0055, 1'b1, 1'b1},
            '{1'b1, 1'b1, 2'b01, 16'h0077, 16'h0000, 16'h0000, 1'b0, 1'b0},
            '{1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}
        };

        for (int i = 0; i < NVEC; i++) begin
            reset      = tbl[i].rst;
            stall      = tbl[i].stl;
            select     = tbl[i].sel;
            input_data = {tbl[i].in1, tbl[i].in0};
            @(posedge clk);
            #1;
            chk($sformatf("row%0d data", i), 64'(output_data), 64'(tbl[i].exp_d));
            chk($sformatf("row%0d valid", i), 64'(output_valid), 64'(tbl[i].exp_v));
            chk($sformatf("row%0d select_err", i), 64'(select_err), 64'(tbl[i].exp_e));
        end

`ifdef DP_REGMX_PARITY_EN
        reset      = 1'b0;
        stall      = 1'b0;
        select     = 2'b01;
        input_data = {16'h0000, 16'h0F0F};
        @(posedge clk);
        #1;
        select = 2'b00;
        @(posedge clk);
        #1;
        chk("par clean valid", 64'(output_valid), 64'd1);
        chk("par clean", 64'(parity_err), 64'd0);
        force u_dut.g_stage[1].u_stage.data = 16'h0F07;
        #1;
        chk("par flipped", 64'(parity_err), 64'd1);
        release u_dut.g_stage[1].u_stage.data;
        @(posedge clk);
        #1;
        chk("par after bubble", 64'(parity_err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
